// File: rtl/synth_cfg_ctrl.sv
// CPU-side sequencer for the synth-config CDC: MMIO shadow registers, launch snapshot on
// commit, and a 4-phase req/ack handshake with commit coalescing and per-phase timeout.
module synth_cfg_ctrl #(
  parameter int N_VOICES    = 1,
  parameter int AUTO_COMMIT = 0,
  parameter int TIMEOUT     = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [4:0]              wr_addr,
  input  logic [23:0]             wr_data,
  input  logic                    commit,
  output logic [24*N_VOICES-1:0]  cpu_carrier_fcws,
  output logic [23:0]             cpu_mod_fcw,
  output logic [4:0]              cpu_mod_shift,
  output logic [N_VOICES-1:0]     cpu_note_en,
  output logic [4:0]              cpu_synth_shift,
  output logic                    cpu_req,
  input  logic                    cpu_ack,
  output logic                    busy,
  output logic                    pending,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             commit_count
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_SETUP    = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_WAIT_REL = 3'd4;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [24*N_VOICES-1:0] carrier_sh_r, carrier_nx_s, carrier_lr_r;
  logic [23:0]            mod_fcw_sh_r, mod_fcw_nx_s, mod_fcw_lr_r;
  logic [4:0]             mod_shift_sh_r, mod_shift_nx_s, mod_shift_lr_r;
  logic [N_VOICES-1:0]    note_en_sh_r, note_en_nx_s, note_en_lr_r;
  logic [4:0]             synth_shift_sh_r, synth_shift_nx_s, synth_shift_lr_r;

  logic [2:0]       state_r, state_nx_s;
  logic             pending_r, pending_nx_s;
  logic             req_r, req_nx_s;
  logic             busy_r, done_r, err_r;
  logic [15:0]      commit_count_r;
  logic [CNT_W-1:0] phase_cnt_r;

  logic addr_valid_s, err_clr_s, ec_s, hs_done_s, in_wait_s, timeout_hit_s;

  // Write decode: next-shadow values including the write of the current cycle
  always_comb begin
    carrier_nx_s     = carrier_sh_r;
    mod_fcw_nx_s     = mod_fcw_sh_r;
    mod_shift_nx_s   = mod_shift_sh_r;
    note_en_nx_s     = note_en_sh_r;
    synth_shift_nx_s = synth_shift_sh_r;
    addr_valid_s     = 1'b0;
    err_clr_s        = 1'b0;
    if (wr_en) begin
      case (wr_addr)
        5'h10: begin mod_fcw_nx_s = wr_data; addr_valid_s = 1'b1; end
        5'h11: begin mod_shift_nx_s = wr_data[4:0]; addr_valid_s = 1'b1; end
        5'h12: begin note_en_nx_s = wr_data[N_VOICES-1:0]; addr_valid_s = 1'b1; end
        5'h13: begin synth_shift_nx_s = wr_data[4:0]; addr_valid_s = 1'b1; end
        5'h14: begin note_en_nx_s = note_en_sh_r | wr_data[N_VOICES-1:0]; addr_valid_s = 1'b1; end
        5'h15: begin note_en_nx_s = note_en_sh_r & ~wr_data[N_VOICES-1:0]; addr_valid_s = 1'b1; end
        5'h16: begin err_clr_s = 1'b1; addr_valid_s = 1'b1; end
        default: begin
          for (int i = 0; i < N_VOICES; i++) begin
            if (wr_addr == 5'(i)) begin
              carrier_nx_s[24*i +: 24] = wr_data;
              addr_valid_s = 1'b1;
            end else begin
              carrier_nx_s[24*i +: 24] = carrier_sh_r[24*i +: 24];
            end
          end
        end
      endcase
    end else begin
      addr_valid_s = 1'b0;
    end
  end

  assign ec_s      = commit || ((AUTO_COMMIT != 0) && addr_valid_s);
  assign in_wait_s = (state_r == ST_WAIT_ACK) || (state_r == ST_WAIT_REL);
  assign hs_done_s = (state_r == ST_WAIT_REL) && !cpu_ack;

  // Handshake FSM next-state, coalescing flag and request level
  always_comb begin
    state_nx_s   = state_r;
    pending_nx_s = pending_r;
    req_nx_s     = req_r;
    case (state_r)
      ST_IDLE: begin
        pending_nx_s = 1'b0;
        if (ec_s || pending_r) state_nx_s = ST_LOAD;
        else                   state_nx_s = ST_IDLE;
      end
      ST_LOAD: begin
        pending_nx_s = pending_r | ec_s;
        state_nx_s   = ST_SETUP;
      end
      ST_SETUP: begin
        pending_nx_s = pending_r | ec_s;
        req_nx_s     = 1'b1;
        state_nx_s   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        pending_nx_s = pending_r | ec_s;
        if (cpu_ack) begin
          req_nx_s   = 1'b0;
          state_nx_s = ST_WAIT_REL;
        end else begin
          req_nx_s   = 1'b1;
        end
      end
      ST_WAIT_REL: begin
        // A commit in the completing cycle goes straight to LOAD instead of via pending
        if (!cpu_ack) begin
          pending_nx_s = 1'b0;
          state_nx_s   = (pending_r || ec_s) ? ST_LOAD : ST_IDLE;
        end else begin
          pending_nx_s = pending_r | ec_s;
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        pending_nx_s = 1'b0;
        req_nx_s     = 1'b0;
      end
    endcase
  end

  assign timeout_hit_s = (TIMEOUT != 0) && in_wait_s && (state_nx_s == state_r) &&
                         (phase_cnt_r == TIMEOUT_C - CNT_W'(1));

  // Shadow registers track every accepted write regardless of state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carrier_sh_r     <= '0;
      mod_fcw_sh_r     <= 24'd0;
      mod_shift_sh_r   <= 5'd0;
      note_en_sh_r     <= '0;
      synth_shift_sh_r <= 5'd0;
    end else begin
      carrier_sh_r     <= carrier_nx_s;
      mod_fcw_sh_r     <= mod_fcw_nx_s;
      mod_shift_sh_r   <= mod_shift_nx_s;
      note_en_sh_r     <= note_en_nx_s;
      synth_shift_sh_r <= synth_shift_nx_s;
    end
  end

  // Launch registers snapshot the shadows only when leaving LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carrier_lr_r     <= '0;
      mod_fcw_lr_r     <= 24'd0;
      mod_shift_lr_r   <= 5'd0;
      note_en_lr_r     <= '0;
      synth_shift_lr_r <= 5'd0;
    end else if (state_r == ST_LOAD) begin
      carrier_lr_r     <= carrier_nx_s;
      mod_fcw_lr_r     <= mod_fcw_nx_s;
      mod_shift_lr_r   <= mod_shift_nx_s;
      note_en_lr_r     <= note_en_nx_s;
      synth_shift_lr_r <= synth_shift_nx_s;
    end
  end

  // FSM state, request, status flags and transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      pending_r      <= 1'b0;
      req_r          <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      commit_count_r <= 16'd0;
    end else begin
      state_r   <= state_nx_s;
      pending_r <= pending_nx_s;
      req_r     <= req_nx_s;
      busy_r    <= (state_nx_s != ST_IDLE);
      done_r    <= hs_done_s;
      if (hs_done_s) commit_count_r <= commit_count_r + 16'd1;
    end
  end

  // Per-phase watchdog; the handshake always completes, err only records the stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt_r <= '0;
      err_r       <= 1'b0;
    end else begin
      if (state_nx_s != state_r)                  phase_cnt_r <= '0;
      else if (in_wait_s && phase_cnt_r != TIMEOUT_C) phase_cnt_r <= phase_cnt_r + CNT_W'(1);
      if (timeout_hit_s)  err_r <= 1'b1;
      else if (err_clr_s) err_r <= 1'b0;
    end
  end

  assign cpu_carrier_fcws = carrier_lr_r;
  assign cpu_mod_fcw      = mod_fcw_lr_r;
  assign cpu_mod_shift    = mod_shift_lr_r;
  assign cpu_note_en      = note_en_lr_r;
  assign cpu_synth_shift  = synth_shift_lr_r;
  assign cpu_req          = req_r;
  assign busy             = busy_r;
  assign pending          = pending_r;
  assign done             = done_r;
  assign err              = err_r;
  assign commit_count     = commit_count_r;

endmodule

// File: tb/tb_synth_cfg_ctrl.sv
// Scoreboard bench for synth_cfg_ctrl: instance A (4 voices, TIMEOUT=8) exercises the handshake,
// instance B (4 voices, AUTO_COMMIT=1) exercises auto-commit and the note-enable mask writes.
module tb_synth_cfg_ctrl;

  typedef struct packed {
    logic [23:0] car0;
    logic [23:0] mfcw;
    logic [4:0]  mshift;
    logic [3:0]  nen;
    logic [4:0]  sshift;
  } launch_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_wr_en, a_commit, a_ack, a_req, a_busy, a_pend, a_done, a_err;
  logic [4:0]  a_wr_addr, a_mshift, a_sshift;
  logic [23:0] a_wr_data, a_mfcw;
  logic [95:0] a_car;
  logic [3:0]  a_nen;
  logic [15:0] a_cnt;

  logic        b_wr_en, b_commit, b_ack, b_req, b_busy, b_pend, b_done, b_err;
  logic [4:0]  b_wr_addr, b_mshift, b_sshift;
  logic [23:0] b_wr_data, b_mfcw;
  logic [95:0] b_car;
  logic [3:0]  b_nen;
  logic [15:0] b_cnt;

  synth_cfg_ctrl #(.N_VOICES(4), .AUTO_COMMIT(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .commit(a_commit), .cpu_carrier_fcws(a_car), .cpu_mod_fcw(a_mfcw), .cpu_mod_shift(a_mshift),
    .cpu_note_en(a_nen), .cpu_synth_shift(a_sshift), .cpu_req(a_req), .cpu_ack(a_ack),
    .busy(a_busy), .pending(a_pend), .done(a_done), .err(a_err), .commit_count(a_cnt));

  synth_cfg_ctrl #(.N_VOICES(4), .AUTO_COMMIT(1), .TIMEOUT(1023)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .commit(b_commit), .cpu_carrier_fcws(b_car), .cpu_mod_fcw(b_mfcw), .cpu_mod_shift(b_mshift),
    .cpu_note_en(b_nen), .cpu_synth_shift(b_sshift), .cpu_req(b_req), .cpu_ack(b_ack),
    .busy(b_busy), .pending(b_pend), .done(b_done), .err(b_err), .commit_count(b_cnt));

  int      n_cmp = 0;
  int      n_bad = 0;
  int      a_done_cnt = 0;
  int      a_ack_dly = 4;
  launch_t sh;
  launch_t sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic launch_t model_wr(input launch_t s, input logic [4:0] ad, input logic [23:0] d);
    launch_t r;
    r = s;
    case (ad)
      5'h00:   r.car0   = d;
      5'h10:   r.mfcw   = d;
      5'h11:   r.mshift = d[4:0];
      5'h12:   r.nen    = d[3:0];
      5'h13:   r.sshift = d[4:0];
      5'h14:   r.nen    = s.nen | d[3:0];
      5'h15:   r.nen    = s.nen & ~d[3:0];
      default: r        = s;
    endcase
    return r;
  endfunction

  // CDC ack responder for A: follows req after a_ack_dly cycles in both directions
  initial begin
    int rc;
    rc = 0;
    a_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        a_ack = 1'b0;
        rc = 0;
      end else if (a_req != a_ack) begin
        rc++;
        if (rc >= a_ack_dly) begin
          a_ack = a_req;
          rc = 0;
        end
      end else begin
        rc = 0;
      end
    end
  end

  // B's CDC answers immediately
  initial begin
    b_ack = 1'b0;
    forever begin
      @(negedge clk);
      b_ack = b_req;
    end
  end

  // Scoreboard: each rising req must present the next expected launch snapshot
  initial begin
    logic    req_q;
    launch_t got, exp;
    req_q = 1'b0;
    forever begin
      @(negedge clk);
      if (a_req && !req_q) begin
        got = '{car0: a_car[23:0], mfcw: a_mfcw, mshift: a_mshift, nen: a_nen, sshift: a_sshift};
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_req", 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp = sb_q.pop_front();
          check_eq("sb_launch", 64'(got), 64'(exp));
        end
        check_eq("sb_car_hi", a_car[95:24], 72'd0);
      end
      if (a_done) a_done_cnt++;
      req_q = a_req;
    end
  end

  task automatic a_write(input logic [4:0] ad, input logic [23:0] d, input logic cm);
    sh = model_wr(sh, ad, d);
    a_wr_en = 1'b1; a_wr_addr = ad; a_wr_data = d; a_commit = cm;
    @(negedge clk);
    a_wr_en = 1'b0; a_commit = 1'b0;
  endtask

  task automatic a_commit_pulse();
    a_commit = 1'b1;
    @(negedge clk);
    a_commit = 1'b0;
  endtask

  task automatic b_write(input logic [4:0] ad, input logic [23:0] d);
    b_wr_en = 1'b1; b_wr_addr = ad; b_wr_data = d;
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!(sel ? b_busy : a_busy)) break;
    end
    check_eq({tag, "_idle"}, 64'(sel ? b_busy : a_busy), 64'd0);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_req) break;
    end
    check_eq({tag, "_req"}, 64'(a_req), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    a_wr_en = 1'b0; a_wr_addr = 5'd0; a_wr_data = 24'd0; a_commit = 1'b0;
    b_wr_en = 1'b0; b_wr_addr = 5'd0; b_wr_data = 24'd0; b_commit = 1'b0;
    sh = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_busy", {a_req, a_busy, a_pend, a_done, a_err}, 5'd0);
    check_eq("rst_launch", {a_car, a_mfcw, a_mshift, a_nen, a_sshift}, 134'd0);
    check_eq("rst_count", a_cnt, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic transfer and its latency
    a_write(5'h10, 24'h123456, 1'b0);
    sb_q.push_back(sh);
    a_commit_pulse();
    check_eq("t2_T1_fcw", a_mfcw, 24'd0);
    check_eq("t2_T1_busy", a_busy, 1'b1);
    @(negedge clk);
    check_eq("t2_T2_fcw", a_mfcw, 24'h123456);
    check_eq("t2_T2_req", a_req, 1'b0);
    @(negedge clk);
    check_eq("t2_T3_req", a_req, 1'b1);
    wait_idle(1'b0, "t2");
    check_eq("t2_count", a_cnt, 16'd1);
    check_eq("t2_done", a_done_cnt, 1);

    // Shadow write during WAIT_ACK must not reach the launch regs
    sb_q.push_back(sh);
    a_commit_pulse();
    wait_req("t3");
    a_write(5'h10, 24'hAAAAAA, 1'b0);
    check_eq("t3_hold_fcw", a_mfcw, 24'h123456);
    wait_idle(1'b0, "t3a");
    check_eq("t3_after_fcw", a_mfcw, 24'h123456);
    sb_q.push_back(sh);
    a_commit_pulse();
    wait_idle(1'b0, "t3b");
    check_eq("t3_later_fcw", a_mfcw, 24'hAAAAAA);

    // Write+commit in the LOAD cycle: launched at once, plus one coalesced follow-up
    a_write(5'h13, 24'h3, 1'b1);
    a_write(5'h10, 24'h555555, 1'b1);
    sb_q.push_back(sh);
    sb_q.push_back(sh);
    check_eq("t3_load_pend", a_pend, 1'b1);
    wait_idle(1'b0, "t3c");
    check_eq("t3_load_fcw", a_mfcw, 24'h555555);
    check_eq("t3_count", a_cnt, 16'd5);

    // Three commits in one handshake coalesce into exactly one extra transfer
    a_write(5'h12, 24'h9, 1'b1);
    sb_q.push_back(sh);
    wait_req("t4");
    a_write(5'h11, 24'h1F, 1'b1);
    sb_q.push_back(sh);
    @(negedge clk);
    a_commit_pulse();
    @(negedge clk);
    a_commit_pulse();
    check_eq("t4_pend", a_pend, 1'b1);
    wait_idle(1'b0, "t4");
    check_eq("t4_count", a_cnt, 16'd7);
    check_eq("t4_pend_clr", a_pend, 1'b0);
    check_eq("t4_mshift", a_mshift, 5'h1F);

    // Phase timeout: err at cycle 8 of WAIT_ACK, handshake still completes
    a_ack_dly = 20;
    a_write(5'h00, 24'hABCDEF, 1'b0);
    sb_q.push_back(sh);
    a_commit_pulse();
    wait_req("t5");
    repeat (7) @(negedge clk);
    check_eq("t5_err_c7", a_err, 1'b0);
    @(negedge clk);
    check_eq("t5_err_c8", a_err, 1'b1);
    check_eq("t5_req_c8", a_req, 1'b1);
    wait_idle(1'b0, "t5");
    check_eq("t5_err_sticky", a_err, 1'b1);
    check_eq("t5_count", a_cnt, 16'd8);
    a_write(5'h16, 24'h0, 1'b0);
    check_eq("t5_err_clr", a_err, 1'b0);
    check_eq("t5_done_total", a_done_cnt, 8);
    a_ack_dly = 4;

    // Auto-commit and note-enable mask writes on B
    b_write(5'h14, 24'h5);
    wait_idle(1'b1, "t6a");
    check_eq("t6_nen_set", b_nen, 4'b0101);
    b_write(5'h15, 24'h1);
    wait_idle(1'b1, "t6b");
    check_eq("t6_nen_clr", b_nen, 4'b0100);
    check_eq("t6_count", b_cnt, 16'd2);
    b_write(5'h1F, 24'hFFFFFF);
    check_eq("t6_unmapped_busy", b_busy, 1'b0);
    repeat (6) @(negedge clk);
    check_eq("t6_unmapped_count", b_cnt, 16'd2);

    // Reset in WAIT_ACK withdraws the request immediately
    a_ack_dly = 20;
    sb_q.push_back(sh);
    a_commit_pulse();
    wait_req("t1r");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t1r_req", a_req, 1'b0);
    check_eq("t1r_busy", a_busy, 1'b0);
    check_eq("t1r_state", {a_mfcw, a_cnt, a_pend}, 41'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_ack_dly = 4;
    sh = '0;
    @(negedge clk);
    sb_q.push_back(sh);
    a_commit_pulse();
    wait_idle(1'b0, "t1r_post");
    check_eq("t1r_post_count", a_cnt, 16'd1);

    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
